nanorv32_pic: RTL and testbench
===============================

# nanorv32_pic

Parametrised priority interrupt controller, successor to the fixed 8-source controller on the nanorv32 APB peripheral bus. It latches up to 32 sources, each configurable as edge or level, with a per-source enable and priority. A threshold and claim/complete handshake arbitrate the sources, and one request line drives the CPU.

## Interface
- NUM_IRQ, 16, number of sources (1..32)
- PRIO_W, 2, priority field width; priority 0 means never interrupt
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- apb_pic_psel  in  1  APB select
- apb_pic_paddr  in  12  APB address; only [7:0] decoded
- apb_pic_penable  in  1  APB enable
- apb_pic_pwrite  in  1  APB write
- apb_pic_pwdata  in  32  APB write data
- pic_apb_prdata  out  32  APB read data; combinational from registers
- pic_apb_pready  out  1  tied 1
- pic_apb_pslverr  out  1  1 during an access to an unmapped offset
- irqs  in  NUM_IRQ  interrupt sources, already synchronous to clk
- irq_ack  in  1  CPU hardware acknowledge; used only with NANORV32_PIC_VECTOR_EN
- pic_irq  out  1  registered interrupt request to the CPU
- pic_irq_id  out  5  winning source id, registered; present only with NANORV32_PIC_VECTOR_EN

## Operation
- Write strobe is psel & ~penable & pwrite (setup phase), so a write takes effect at the end of the setup cycle. Reads are combinational for the whole transfer. The read side-effect strobe is psel & penable & ~pwrite, active for one cycle.
- Register map (byte offsets):
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C CLEAR: W1C on edge pending bits.
  - 0x10 CLAIM: read returns {valid[31], 26'b0, id[4:0]}; a write of id completes that source.
  - 0x14 THRESHOLD: RW, PRIO_W bits.
  - 0x40+4*i PRIO[i]: RW, PRIO_W bits.
  - Unused bits read 0. Registers for i >= NUM_IRQ are unmapped.
- Pending behaviour:
  - Edge source: pending sets on a rising edge (irqs & ~irqs_q) and holds until CLEAR or claim.
  - Level source: pending equals irqs; it is not latched.
- Eligible[i] = pending & enable & ~in_service & (prio[i] > threshold).
- Winner: the highest prio among eligible sources; on a tie, the lowest index wins.
- A CLAIM read with a winner returns valid=1 and the id, sets in_service[id], and clears pending[id] if that source is edge.
- A CLAIM read with no eligible source returns 0 and has no side effect.
- Complete (write to CLAIM) clears in_service[pwdata[4:0]]. It is ignored if that bit is already clear or the id is >= NUM_IRQ.
- in_service masks only its own source; other sources can still claim, so software controls nesting.
- Simultaneous events:
  - Edge set and CLEAR in the same cycle: set wins.
  - Edge set and claim of the same source in the same cycle: pending stays 1.
  - Complete and claim of the same id in the same cycle: claim wins, so in_service = 1.
- Reset (rst_n low at a clk edge) clears all state, including in-flight in_service.
- Reset values:
  - pic_irq = 0, pic_irq_id = 0, pic_apb_pslverr = 0, pic_apb_prdata = 0 when idle.
  - ENABLE, MODE, PENDING, in_service, THRESHOLD and PRIO are all 0.
  - irqs_q = 0, so a source held high through reset produces an edge on the first cycle after reset if it is in edge mode.

## Timing
- A rising edge on irqs in cycle N sets pending at the N/N+1 boundary. pic_irq asserts one cycle later (2-cycle latency). Level sources have the same latency.
- pic_irq deasserts in the cycle after the claim read's access phase, provided no other source is eligible.
- ENABLE, PRIO and THRESHOLD writes affect pic_irq one cycle after the write edge.

## Configuration
- NANORV32_PIC_VECTOR_EN defined:
  - pic_irq_id is present and is registered alongside pic_irq.
  - irq_ack high for one cycle performs a claim of the current winner, with side effects identical to a CLAIM read.
  - If irq_ack and a CLAIM read occur in the same cycle, only one claim is performed.
- NANORV32_PIC_VECTOR_EN undefined: pic_irq_id is absent, irq_ack is ignored, and claiming is done by CLAIM reads only.

## Structure
- Package nanorv32_pic_pkg:
  - register offset localparams;
  - ID_W = 5;
  - MAX_IRQ = 32.
- Sub-module nanorv32_pic_arb: a combinational priority tree over NUM_IRQ eligible bits and priorities, producing {valid, id, prio}.

## Test plan
- NUM_IRQ=16. Source 3 in edge mode, enabled, prio 2, threshold 0; pulse irqs[3] for 1 cycle. Expect: pic_irq high 2 cycles later; CLAIM reads 0x80000003; pic_irq drops; a second CLAIM read returns 0.
- Sources 5 and 9 in level mode, both prio 1, both high. Expect: claim returns 5. After complete(5), with 5 still high, the next claim returns 5 again. With 5 dropped after complete, the next claim returns 9.
- Source 7 prio 3, source 2 prio 1, both pending. Expect: claim returns 7. Then set threshold to 1: source 2 is no longer eligible and pic_irq = 0.
- Edge on source 4 in the same cycle as a CLEAR write of bit 4. Expect: PENDING[4] = 1. Then CLEAR bit 4 alone gives PENDING = 0.
- Access to offset 0x3C, or 0x40+4*16 with NUM_IRQ=16. Expect: pslverr = 1, prdata = 0, no state change. Pulse rst_n low mid-claim: all registers return to 0 and pic_irq = 0.
- With NANORV32_PIC_VECTOR_EN: source 1 pending. Expect: pic_irq_id = 1; irq_ack pulse sets in_service[1]; a CLAIM read in the same cycle does not claim a second source.

Source files
------------

// File: rtl/nanorv32_pic_pkg.sv
// nanorv32_pic_pkg: register offsets, sizing constants and the APB offset
// decoder shared by the interrupt controller.
package nanorv32_pic_pkg;

    localparam int unsigned ID_W    = 5;
    localparam int unsigned MAX_IRQ = 32;

    localparam logic [7:0] OFF_PENDING   = 8'h00;
    localparam logic [7:0] OFF_ENABLE    = 8'h04;
    localparam logic [7:0] OFF_MODE      = 8'h08;
    localparam logic [7:0] OFF_CLEAR     = 8'h0C;
    localparam logic [7:0] OFF_CLAIM     = 8'h10;
    localparam logic [7:0] OFF_THRESHOLD = 8'h14;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h40;

    typedef enum logic [2:0] {
        REG_PENDING,
        REG_ENABLE,
        REG_MODE,
        REG_CLEAR,
        REG_CLAIM,
        REG_THRESHOLD,
        REG_PRIO,
        REG_NONE
    } reg_sel_e;

    // PRIO[i] lives at 0x40+4*i and only exists for i < num_irq
    function automatic reg_sel_e decode_offset(input logic [7:0] off,
                                               input int unsigned num_irq);
        logic [7:0] rel;
        reg_sel_e   sel;
        rel = off - OFF_PRIO_BASE;
        sel = REG_NONE;
        case (off)
            OFF_PENDING:   sel = REG_PENDING;
            OFF_ENABLE:    sel = REG_ENABLE;
            OFF_MODE:      sel = REG_MODE;
            OFF_CLEAR:     sel = REG_CLEAR;
            OFF_CLAIM:     sel = REG_CLAIM;
            OFF_THRESHOLD: sel = REG_THRESHOLD;
            default: begin
                if (off >= OFF_PRIO_BASE && off[1:0] == 2'b00 &&
                    32'(rel[7:2]) < num_irq) begin
                    sel = REG_PRIO;
                end
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/nanorv32_pic_arb.sv
// nanorv32_pic_arb: combinational arbiter over the eligible sources.
// Picks the highest priority; ties go to the lowest index.
module nanorv32_pic_arb
    import nanorv32_pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned PRIO_W  = 2
) (
    input  logic [NUM_IRQ-1:0]        elig_i,
    input  logic [NUM_IRQ*PRIO_W-1:0] prio_i,
    output logic                      valid_o,
    output logic [ID_W-1:0]           id_o,
    output logic [PRIO_W-1:0]         prio_o
);

    logic              best_v;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_p;

    // Ascending scan with strict '>' so an equal later priority never displaces an earlier index
    always_comb begin
        best_v  = 1'b0;
        best_id = '0;
        best_p  = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (elig_i[i] && (!best_v || prio_i[i*PRIO_W +: PRIO_W] > best_p)) begin
                best_v  = 1'b1;
                best_id = ID_W'(i);
                best_p  = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign valid_o = best_v;
    assign id_o    = best_id;
    assign prio_o  = best_p;

endmodule

// File: rtl/nanorv32_pic.sv
// nanorv32_pic: APB priority interrupt controller with edge/level sources,
// per-source enable and priority, threshold and claim/complete handshake.
// Optional macro NANORV32_PIC_VECTOR_EN adds pic_irq_id and hardware claim via irq_ack.
module nanorv32_pic
    import nanorv32_pic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 16,
    parameter int unsigned PRIO_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apb_pic_psel,
    input  logic [11:0]        apb_pic_paddr,
    input  logic               apb_pic_penable,
    input  logic               apb_pic_pwrite,
    input  logic [31:0]        apb_pic_pwdata,
    output logic [31:0]        pic_apb_prdata,
    output logic               pic_apb_pready,
    output logic               pic_apb_pslverr,
    input  logic [NUM_IRQ-1:0] irqs,
    input  logic               irq_ack,
    output logic               pic_irq
`ifdef NANORV32_PIC_VECTOR_EN
    ,
    output logic [ID_W-1:0]    pic_irq_id
`endif
);

    logic [NUM_IRQ-1:0]        pending_q, pending_d;
    logic [NUM_IRQ-1:0]        enable_q, enable_d;
    logic [NUM_IRQ-1:0]        mode_q, mode_d;
    logic [NUM_IRQ-1:0]        in_service_q, in_service_d;
    logic [NUM_IRQ-1:0]        irqs_q;
    logic [PRIO_W-1:0]         thresh_q, thresh_d;
    logic [NUM_IRQ*PRIO_W-1:0] prio_q, prio_d;
    logic                      pic_irq_q, pic_irq_d;
    logic [ID_W-1:0]           pic_irq_id_q, pic_irq_id_d;

    logic [7:0]         off;
    logic [7:0]         prio_rel;
    logic [ID_W-1:0]    prio_idx;
    reg_sel_e           sel;
    logic               wr_en, rd_en, claim;
    logic [NUM_IRQ-1:0] eligible, claim_mask, complete_mask, clear_mask, next_elig;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic [31:0]        rdata;
    logic               unused_ok;

    assign off      = apb_pic_paddr[7:0];
    assign sel      = decode_offset(off, NUM_IRQ);
    assign prio_rel = off - OFF_PRIO_BASE;
    assign prio_idx = prio_rel[6:2];
    assign wr_en    = apb_pic_psel & ~apb_pic_penable & apb_pic_pwrite;
    assign rd_en    = apb_pic_psel & apb_pic_penable & ~apb_pic_pwrite;

    // Eligibility: pending, enabled, not in service and strictly above threshold
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & ~in_service_q[i] &
                          (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
        end
    end

    nanorv32_pic_arb #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) u_arb (
        .elig_i  (eligible),
        .prio_i  (prio_q),
        .valid_o (win_valid),
        .id_o    (win_id),
        .prio_o  (win_prio)
    );

`ifdef NANORV32_PIC_VECTOR_EN
    // A CLAIM read and irq_ack in the same cycle both target the one winner, so only one claim happens
    assign claim = win_valid & ((rd_en & (sel == REG_CLAIM)) | irq_ack);
`else
    assign claim = win_valid & rd_en & (sel == REG_CLAIM);
`endif

    // One-hot masks for claim, complete and W1C clear
    always_comb begin
        claim_mask    = '0;
        complete_mask = '0;
        clear_mask    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            claim_mask[i]    = claim & (win_id == ID_W'(i));
            complete_mask[i] = wr_en & (sel == REG_CLAIM) & (apb_pic_pwdata[4:0] == ID_W'(i));
        end
        if (wr_en && sel == REG_CLEAR) begin
            clear_mask = apb_pic_pwdata[NUM_IRQ-1:0];
        end
    end

    // Next-state for configuration, pending and in-service state
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        thresh_d = thresh_q;
        prio_d   = prio_q;
        if (wr_en) begin
            case (sel)
                REG_ENABLE:    enable_d = apb_pic_pwdata[NUM_IRQ-1:0];
                REG_MODE:      mode_d   = apb_pic_pwdata[NUM_IRQ-1:0];
                REG_THRESHOLD: thresh_d = apb_pic_pwdata[PRIO_W-1:0];
                REG_PRIO: begin
                    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                        if (prio_idx == ID_W'(i)) begin
                            prio_d[i*PRIO_W +: PRIO_W] = apb_pic_pwdata[PRIO_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
        // New edges are ORed in last so they win over CLEAR and claim
        pending_d    = (mode_q & ((pending_q & ~clear_mask & ~claim_mask) | (irqs & ~irqs_q))) |
                       (~mode_q & irqs);
        // Claim is ORed in last so it wins over a same-id complete
        in_service_d = (in_service_q & ~complete_mask) | claim_mask;
    end

    // The request drops right after a claim unless some other source is still eligible
    assign next_elig = eligible & ~claim_mask;
    assign pic_irq_d = |next_elig;

`ifdef NANORV32_PIC_VECTOR_EN
    logic              nxt_valid;
    logic [PRIO_W-1:0] nxt_prio;

    nanorv32_pic_arb #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) u_arb_next (
        .elig_i  (next_elig),
        .prio_i  (prio_q),
        .valid_o (nxt_valid),
        .id_o    (pic_irq_id_d),
        .prio_o  (nxt_prio)
    );
    assign pic_irq_id = pic_irq_id_q;
    assign unused_ok  = ^{apb_pic_paddr[11:8], apb_pic_pwdata, prio_rel[7], prio_rel[1:0],
                          win_prio, nxt_valid, nxt_prio};
`else
    assign pic_irq_id_d = '0;
    assign unused_ok    = ^{apb_pic_paddr[11:8], apb_pic_pwdata, prio_rel[7], prio_rel[1:0],
                            win_prio, irq_ack, pic_irq_id_q};
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
            irqs_q       <= '0;
            thresh_q     <= '0;
            prio_q       <= '0;
            pic_irq_q    <= 1'b0;
            pic_irq_id_q <= '0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
            irqs_q       <= irqs;
            thresh_q     <= thresh_d;
            prio_q       <= prio_d;
            pic_irq_q    <= pic_irq_d;
            pic_irq_id_q <= pic_irq_id_d;
        end
    end

    // Combinational read mux; zero when not selected or unmapped
    always_comb begin
        rdata = '0;
        if (apb_pic_psel) begin
            case (sel)
                REG_PENDING:   rdata[NUM_IRQ-1:0] = pending_q;
                REG_ENABLE:    rdata[NUM_IRQ-1:0] = enable_q;
                REG_MODE:      rdata[NUM_IRQ-1:0] = mode_q;
                REG_CLAIM:     rdata = {win_valid, 26'b0, win_id};
                REG_THRESHOLD: rdata[PRIO_W-1:0] = thresh_q;
                REG_PRIO: begin
                    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                        if (prio_idx == ID_W'(i)) begin
                            rdata[PRIO_W-1:0] = prio_q[i*PRIO_W +: PRIO_W];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pic_apb_prdata  = rdata;
    assign pic_apb_pready  = 1'b1;
    assign pic_apb_pslverr = apb_pic_psel & (sel == REG_NONE);
    assign pic_irq         = pic_irq_q;

endmodule

// File: tb/tb_nanorv32_pic.sv
// tb_nanorv32_pic: directed self-checking bench for nanorv32_pic (NUM_IRQ=16, PRIO_W=2).
module tb_nanorv32_pic;

    localparam logic [11:0] A_PENDING = 12'h000;
    localparam logic [11:0] A_ENABLE  = 12'h004;
    localparam logic [11:0] A_MODE    = 12'h008;
    localparam logic [11:0] A_CLEAR   = 12'h00C;
    localparam logic [11:0] A_CLAIM   = 12'h010;
    localparam logic [11:0] A_THRESH  = 12'h014;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [15:0] irqs;
    logic        irq_ack;
    logic        pic_irq;
`ifdef NANORV32_PIC_VECTOR_EN
    logic [4:0]  pic_irq_id;
`endif

    int checks = 0;
    int errors = 0;

    nanorv32_pic #(.NUM_IRQ(16), .PRIO_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .apb_pic_psel    (psel),
        .apb_pic_paddr   (paddr),
        .apb_pic_penable (penable),
        .apb_pic_pwrite  (pwrite),
        .apb_pic_pwdata  (pwdata),
        .pic_apb_prdata  (prdata),
        .pic_apb_pready  (pready),
        .pic_apb_pslverr (pslverr),
        .irqs            (irqs),
        .irq_ack         (irq_ack),
        .pic_irq         (pic_irq)
`ifdef NANORV32_PIC_VECTOR_EN
        ,
        .pic_irq_id      (pic_irq_id)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [11:0] prio_addr(input int i);
        return 12'(32'h40 + 4 * i);
    endfunction

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk); penable = 1'b1;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk); penable = 1'b1; #1; d = prdata; err = pslverr;
        @(negedge clk); psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irqs = '0; irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        @(negedge clk); #1;
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", pic_irq); end
        checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata_idle: got %h expected 0", prdata); end
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b expected 0", pslverr); end
        checks++; if (pready !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b expected 1", pready); end
`ifdef NANORV32_PIC_VECTOR_EN
        checks++; if (pic_irq_id !== 5'd0) begin errors++; $display("FAIL reset_irq_id: got %0d expected 0", pic_irq_id); end
`endif
        apb_read(A_ENABLE, d, e);
        checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_enable: got %h err %b expected 0", d, e); end
        apb_read(A_MODE, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mode: got %h expected 0", d); end
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
        apb_read(prio_addr(3), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_prio3: got %h expected 0", d); end
    endtask

    task automatic test_edge();
        logic [31:0] d; logic e;
        apb_write(A_MODE, 32'h0000_0008);
        apb_write(A_ENABLE, 32'h0000_0008);
        apb_write(prio_addr(3), 32'h2);
        apb_write(A_THRESH, 32'h0);
        @(negedge clk); irqs[3] = 1'b1;
        @(negedge clk); irqs[3] = 1'b0;
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL edge_latency1: got %b expected 0", pic_irq); end
        @(negedge clk);
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL edge_latency2: got %b expected 1", pic_irq); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0003) begin errors++; $display("FAIL edge_claim: got %h expected 80000003", d); end
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL edge_irq_drop: got %b expected 0", pic_irq); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_claim_empty: got %h expected 0", d); end
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_pending_cleared: got %h expected 0", d); end
        apb_write(A_CLAIM, 32'd3);
        apb_write(A_ENABLE, 32'h0);
        apb_write(A_MODE, 32'h0);
    endtask

    task automatic test_level();
        logic [31:0] d; logic e;
        apb_write(A_ENABLE, 32'h0000_0220);
        apb_write(prio_addr(5), 32'h1);
        apb_write(prio_addr(9), 32'h1);
        @(negedge clk); irqs[5] = 1'b1; irqs[9] = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL level_irq: got %b expected 1", pic_irq); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0005) begin errors++; $display("FAIL level_claim_tie: got %h expected 80000005", d); end
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL level_irq_held: got %b expected 1", pic_irq); end
        apb_write(A_CLAIM, 32'd5);
        repeat (2) @(negedge clk);
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0005) begin errors++; $display("FAIL level_reclaim: got %h expected 80000005", d); end
        irqs[5] = 1'b0;
        apb_write(A_CLAIM, 32'd5);
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0009) begin errors++; $display("FAIL level_claim9: got %h expected 80000009", d); end
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL level_irq_drop: got %b expected 0", pic_irq); end
        irqs[9] = 1'b0;
        apb_write(A_CLAIM, 32'd9);
        apb_write(A_ENABLE, 32'h0);
    endtask

    task automatic test_prio_thresh();
        logic [31:0] d; logic e;
        apb_write(A_MODE, 32'h0000_0084);
        apb_write(A_ENABLE, 32'h0000_0084);
        apb_write(prio_addr(7), 32'h3);
        apb_write(prio_addr(2), 32'h1);
        @(negedge clk); irqs[7] = 1'b1; irqs[2] = 1'b1;
        @(negedge clk); irqs[7] = 1'b0; irqs[2] = 1'b0;
        @(negedge clk);
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL prio_irq: got %b expected 1", pic_irq); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL prio_claim7: got %h expected 80000007", d); end
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL prio_irq_held: got %b expected 1", pic_irq); end
        apb_write(A_THRESH, 32'h1);
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL thresh_masks: got %b expected 0", pic_irq); end
        apb_read(A_THRESH, d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL thresh_read: got %h expected 1", d); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL thresh_claim_empty: got %h expected 0", d); end
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("FAIL prio_pending: got %h expected 00000004", d); end
        apb_write(A_THRESH, 32'h0);
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL thresh_release: got %b expected 1", pic_irq); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL prio_claim2: got %h expected 80000002", d); end
        apb_write(A_CLAIM, 32'd7);
        apb_write(A_CLAIM, 32'd2);
        apb_write(A_ENABLE, 32'h0);
        apb_write(A_MODE, 32'h0);
    endtask

    task automatic test_clear_collision();
        logic [31:0] d; logic e;
        apb_write(A_MODE, 32'h0000_0010);
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_CLEAR;
        pwdata = 32'h0000_0010; irqs[4] = 1'b1;
        @(negedge clk); penable = 1'b1; irqs[4] = 1'b0;
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0000_0010) begin errors++; $display("FAIL clear_vs_set: got %h expected 00000010", d); end
        apb_write(A_CLEAR, 32'h0000_0010);
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_alone: got %h expected 0", d); end
        apb_write(A_MODE, 32'h0);
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic e;
        apb_read(12'h03C, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_3c: got data %h err %b expected 0 err 1", d, e); end
        apb_read(12'h080, d, e);
        checks++; if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL unmapped_prio16: got data %h err %b expected 0 err 1", d, e); end
        apb_write(12'h080, 32'h3);
        apb_write(12'h03C, 32'hFFFF_FFFF);
        apb_read(prio_addr(0), d, e);
        checks++; if (e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL unmapped_nochange_prio0: got data %h err %b expected 0 err 0", d, e); end
        apb_read(prio_addr(15), d, e);
        checks++; if (e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL prio15_mapped: got data %h err %b expected 0 err 0", d, e); end
        apb_read(A_ENABLE, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_nochange_enable: got %h expected 0", d); end
    endtask

    task automatic test_reset_midclaim();
        logic [31:0] d; logic e;
        apb_write(A_MODE, 32'h0000_0048);
        apb_write(A_ENABLE, 32'h0000_0048);
        apb_write(prio_addr(3), 32'h3);
        apb_write(prio_addr(6), 32'h2);
        apb_write(A_THRESH, 32'h1);
        @(negedge clk); irqs[3] = 1'b1; irqs[6] = 1'b1;
        @(negedge clk); irqs[3] = 1'b0; irqs[6] = 1'b0;
        @(negedge clk);
        checks++; if (pic_irq !== 1'b1) begin errors++; $display("FAIL rst_pre_irq: got %b expected 1", pic_irq); end
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CLAIM;
        @(negedge clk); penable = 1'b1; rst_n = 1'b0;
        @(negedge clk); psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
        checks++; if (pic_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", pic_irq); end
        apb_read(A_ENABLE, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_enable: got %h expected 0", d); end
        apb_read(A_MODE, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mode: got %h expected 0", d); end
        apb_read(A_PENDING, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_pending: got %h expected 0", d); end
        apb_read(A_THRESH, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_thresh: got %h expected 0", d); end
        apb_read(prio_addr(3), d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_prio3: got %h expected 0", d); end
        apb_write(A_MODE, 32'h0000_0008);
        apb_write(A_ENABLE, 32'h0000_0008);
        apb_write(prio_addr(3), 32'h1);
        @(negedge clk); irqs[3] = 1'b1;
        @(negedge clk); irqs[3] = 1'b0;
        @(negedge clk);
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0003) begin errors++; $display("FAIL rst_in_service_cleared: got %h expected 80000003", d); end
        apb_write(A_CLAIM, 32'd3);
        apb_write(A_ENABLE, 32'h0);
        apb_write(A_MODE, 32'h0);
    endtask

`ifdef NANORV32_PIC_VECTOR_EN
    task automatic test_vector();
        logic [31:0] d; logic e;
        apb_write(A_MODE, 32'h0000_0006);
        apb_write(A_ENABLE, 32'h0000_0006);
        apb_write(prio_addr(1), 32'h1);
        apb_write(prio_addr(2), 32'h1);
        @(negedge clk); irqs[1] = 1'b1; irqs[2] = 1'b1;
        @(negedge clk); irqs[1] = 1'b0; irqs[2] = 1'b0;
        @(negedge clk);
        checks++; if (pic_irq !== 1'b1 || pic_irq_id !== 5'd1) begin errors++; $display("FAIL vec_id: got irq %b id %0d expected 1 id 1", pic_irq, pic_irq_id); end
        @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CLAIM;
        @(negedge clk); penable = 1'b1; irq_ack = 1'b1; #1; d = prdata;
        checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL vec_claim_same_cycle: got %h expected 80000001", d); end
        @(negedge clk); psel = 1'b0; penable = 1'b0; irq_ack = 1'b0;
        checks++; if (pic_irq !== 1'b1 || pic_irq_id !== 5'd2) begin errors++; $display("FAIL vec_next_id: got irq %b id %0d expected 1 id 2", pic_irq, pic_irq_id); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL vec_single_claim: got %h expected 80000002", d); end
        apb_read(A_CLAIM, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL vec_in_service1: got %h expected 0", d); end
        apb_write(A_CLAIM, 32'd1);
        apb_write(A_CLAIM, 32'd2);
        apb_write(A_ENABLE, 32'h0);
    endtask
`endif

    initial begin
        do_reset();
        test_reset();
        test_edge();
        test_level();
        test_prio_thresh();
        test_clear_collision();
        test_unmapped();
        test_reset_midclaim();
`ifdef NANORV32_PIC_VECTOR_EN
        test_vector();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
